// File: rtl/nf_uart_rx_fifo_pkg.sv
// rtl/nf_uart_rx_fifo_pkg.sv - shared types and constants for the UART receive path
package nf_uart_pkg;

    localparam int NF_UART_DW = 8;

    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_ACK   = 2'd1,
        CAP_DRAIN = 2'd2
    } nf_uart_rx_cap_e;

endpackage

// File: rtl/nf_uart_rx_fifo_if.sv
// rtl/nf_uart_rx_fifo_if.sv - receiver handshake plus bus-side read/status signals
interface nf_uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 3
);
    import nf_uart_pkg::*;

    logic [NF_UART_DW-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_val_set;
    logic                  rd_req;
    logic [NF_UART_DW-1:0] rd_data;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  ovf;
    logic                  ovf_clr;
    logic                  fifo_clr;

    modport master (
        output rx_data, rx_valid, rd_req, ovf_clr, fifo_clr,
        input  rx_val_set, rd_data, empty, full, count, ovf
    );

    modport slave (
        input  rx_data, rx_valid, rd_req, ovf_clr, fifo_clr,
        output rx_val_set, rd_data, empty, full, count, ovf
    );

endinterface

// File: rtl/nf_uart_rx_fifo_sync_fifo.sv
// rtl/nf_uart_rx_fifo_sync_fifo.sv - show-ahead synchronous FIFO with wrap-bit pointers and flush
module nf_sync_fifo #(
    parameter int DW         = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [DW-1:0]       wr_data,
    input  logic                rd_en,
    output logic [DW-1:0]       rd_data,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] count
);

    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [DW-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;

    assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
    assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];

    // Flush wins over any same-cycle write or read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem[wr_idx] <= wr_data;
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_idx == rd_idx) && (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = empty ? '0 : mem[rd_idx];

endmodule

// File: rtl/nf_uart_rx_fifo.sv
// rtl/nf_uart_rx_fifo.sv - captures receiver bytes into a FIFO, acks each once, drops and flags on overflow
module nf_uart_rx_fifo
    import nf_uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                resetn,
    nf_uart_rx_fifo_if.slave    bus
);

    nf_uart_rx_cap_e state;
    nf_uart_rx_cap_e state_nxt;

    logic capture;
    logic pop_ok;
    logic push_ok;
    logic drop;
    logic ovf_q;
    logic fifo_empty;
    logic fifo_full;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= CAP_IDLE;
        else         state <= state_nxt;
    end

    // DRAIN holds off re-capture while the receiver still asserts the acked byte.
    always_comb begin
        state_nxt = state;
        case (state)
            CAP_IDLE:  if (bus.rx_valid) state_nxt = CAP_ACK;
            CAP_ACK:   state_nxt = CAP_DRAIN;
            CAP_DRAIN: if (!bus.rx_valid) state_nxt = CAP_IDLE;
            default:   state_nxt = CAP_IDLE;
        endcase
    end

    assign bus.rx_val_set = (state == CAP_ACK);

    assign capture = (state == CAP_IDLE) && bus.rx_valid;
    assign pop_ok  = bus.rd_req && !fifo_empty;
    assign push_ok = capture && (!fifo_full || pop_ok);
    // A flush discards the incoming byte silently rather than counting it as lost.
    assign drop    = capture && fifo_full && !pop_ok && !bus.fifo_clr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)          ovf_q <= 1'b0;
        else if (drop)        ovf_q <= 1'b1;
        else if (bus.ovf_clr) ovf_q <= 1'b0;
    end

    assign bus.ovf   = ovf_q;
    assign bus.empty = fifo_empty;
    assign bus.full  = fifo_full;

    nf_sync_fifo #(
        .DW         (NF_UART_DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (bus.fifo_clr),
        .wr_en   (push_ok),
        .wr_data (bus.rx_data),
        .rd_en   (pop_ok),
        .rd_data (bus.rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (bus.count)
    );

endmodule

// File: tb/tb_nf_uart_rx_fifo.sv
// tb/tb_nf_uart_rx_fifo.sv - scoreboard bench for nf_uart_rx_fifo
module tb_nf_uart_rx_fifo;

    logic clk = 1'b0;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    nf_uart_rx_fifo_if #(.DEPTH_LOG2(3)) bus ();

    nf_uart_rx_fifo #(.DEPTH_LOG2(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit accept, input bit clr_ovf);
        int waited;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        bus.ovf_clr  = clr_ovf;
        if (accept) q.push_back(b);
        tick;
        bus.ovf_clr = 1'b0;
        waited = 0;
        while (bus.rx_val_set !== 1'b1 && waited < 5) begin
            tick;
            waited++;
        end
        n_tests++;
        if (bus.rx_val_set !== 1'b1 || waited != 0) begin
            n_fail++;
            $display("FAIL ack_latency byte=%h ack=%b waited=%0d, want ack=1 waited=0", b, bus.rx_val_set, waited);
        end
        tick;
        n_tests++;
        if (bus.rx_val_set !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_single_pulse byte=%h ack=%b want 0", b, bus.rx_val_set);
        end
        bus.rx_valid = 1'b0;
        tick;
    endtask

    task automatic pop_check;
        logic [7:0] exp;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_underflow scoreboard empty, count=%0d want 0", bus.count);
            return;
        end
        exp = q.pop_front();
        if (bus.rd_data !== exp) begin
            n_fail++;
            $display("FAIL pop_data got %h want %h", bus.rd_data, exp);
        end
        bus.rd_req = 1'b1;
        tick;
        bus.rd_req = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        tick;
        tick;
        n_tests++; if (bus.rx_val_set !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", bus.rx_val_set); end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus.full); end
        n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", bus.rd_data); end
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
        resetn = 1'b1;
        tick;
    endtask

    task automatic test_single;
        send_byte(8'hA5, 1'b1, 1'b0);
        n_tests++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", bus.count); end
        n_tests++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL single_empty got %b want 0", bus.empty); end
        pop_check();
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_after got %b want 1", bus.empty); end
        n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL single_rd_data_empty got %h want 00", bus.rd_data); end
    endtask

    task automatic test_fill_wrap;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1, 1'b0);
        n_tests++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", bus.full); end
        n_tests++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0d want 8", bus.count); end
        for (int i = 0; i < 3; i++) pop_check();
        n_tests++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL fill_count_after_pop got %0d want 5", bus.count); end
        for (int i = 9; i <= 11; i++) send_byte(8'(i), 1'b1, 1'b0);
        n_tests++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL wrap_full got %b want 1", bus.full); end
        for (int i = 0; i < 8; i++) pop_check();
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0);
        n_tests++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", bus.ovf); end
        n_tests++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", bus.count); end
        bus.ovf_clr = 1'b1;
        tick;
        bus.ovf_clr = 1'b0;
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", bus.ovf); end
        send_byte(8'hEE, 1'b0, 1'b1);
        n_tests++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b want 1", bus.ovf); end
        bus.ovf_clr = 1'b1;
        tick;
        bus.ovf_clr = 1'b0;
        for (int i = 0; i < 8; i++) pop_check();
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_full_pop;
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i), 1'b1, 1'b0);
        exp = q.pop_front();
        n_tests++; if (bus.rd_data !== exp) begin n_fail++; $display("FAIL fullpop_head got %h want %h", bus.rd_data, exp); end
        bus.rx_data  = 8'h5A;
        bus.rx_valid = 1'b1;
        bus.rd_req   = 1'b1;
        q.push_back(8'h5A);
        tick;
        bus.rd_req = 1'b0;
        n_tests++; if (bus.rx_val_set !== 1'b1) begin n_fail++; $display("FAIL fullpop_ack got %b want 1", bus.rx_val_set); end
        n_tests++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL fullpop_count got %0d want 8", bus.count); end
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf got %b want 0", bus.ovf); end
        tick;
        bus.rx_valid = 1'b0;
        tick;
        for (int i = 0; i < 8; i++) pop_check();
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fullpop_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_corners;
        bus.rd_req = 1'b1;
        tick;
        bus.rd_req = 1'b0;
        n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL empty_pop_count got %0d want 0", bus.count); end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL empty_pop_empty got %b want 1", bus.empty); end
        for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), 1'b1, 1'b0);
        n_tests++; if (bus.count !== 4'd4) begin n_fail++; $display("FAIL clr_pre_count got %0d want 4", bus.count); end
        bus.rx_data  = 8'h77;
        bus.rx_valid = 1'b1;
        bus.fifo_clr = 1'b1;
        tick;
        bus.fifo_clr = 1'b0;
        q.delete();
        n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL clr_count got %0d want 0", bus.count); end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %b want 1", bus.empty); end
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b want 0", bus.ovf); end
        n_tests++; if (bus.rx_val_set !== 1'b1) begin n_fail++; $display("FAIL clr_ack got %b want 1", bus.rx_val_set); end
        tick;
        bus.rx_valid = 1'b0;
        tick;
        send_byte(8'h40, 1'b1, 1'b0);
        pop_check();
    endtask

    task automatic test_reset_mid;
        send_byte(8'h50, 1'b1, 1'b0);
        send_byte(8'h51, 1'b1, 1'b0);
        bus.rx_data  = 8'h3C;
        bus.rx_valid = 1'b1;
        tick;
        n_tests++; if (bus.rx_val_set !== 1'b1) begin n_fail++; $display("FAIL mid_ack_before got %b want 1", bus.rx_val_set); end
        resetn = 1'b0;
        #1;
        q.delete();
        n_tests++; if (bus.rx_val_set !== 1'b0) begin n_fail++; $display("FAIL mid_ack got %b want 0", bus.rx_val_set); end
        n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", bus.count); end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty got %b want 1", bus.empty); end
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got %b want 0", bus.ovf); end
        tick;
        resetn = 1'b1;
        q.push_back(8'h3C);
        tick;
        n_tests++; if (bus.rx_val_set !== 1'b1) begin n_fail++; $display("FAIL mid_recapture_ack got %b want 1", bus.rx_val_set); end
        tick;
        bus.rx_valid = 1'b0;
        tick;
        tick;
        n_tests++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL mid_recapture_count got %0d want 1", bus.count); end
        pop_check();
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_final_empty got %b want 1", bus.empty); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn       = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rd_req   = 1'b0;
        bus.ovf_clr  = 1'b0;
        bus.fifo_clr = 1'b0;
        test_reset();
        test_single();
        test_fill_wrap();
        test_overflow();
        test_full_pop();
        test_corners();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
